// File: rtl/dyn_scan_n_pkg.sv
// Shared helpers for the dyn_scan_n display scanner: one-hot select,
// slot step size and parameter legality.
package dyn_scan_pkg;

  localparam int unsigned MAX_DIGITS = 64;

  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx,
                                                   input int unsigned digits);
    logic [MAX_DIGITS-1:0] v;
    v = '0;
    if (idx < digits && idx < MAX_DIGITS) v[idx] = 1'b1;
    return v;
  endfunction

  // Clock cycles per brightness phase.
  function automatic int unsigned calc_step(input int unsigned prescale,
                                            input int unsigned bright_w);
    return prescale >> bright_w;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

  function automatic bit params_ok(input int unsigned digits,
                                   input int unsigned prescale,
                                   input int unsigned bright_w);
    return (digits >= 2) && (digits <= MAX_DIGITS) &&
           (prescale >= (32'd1 << bright_w)) &&
           ((prescale % (32'd1 << bright_w)) == 0);
  endfunction

endpackage

// File: rtl/dyn_scan_n_if.sv
// Digit data / brightness in, digit select and value out, for dyn_scan_n.
interface dyn_scan_n_if #(
  parameter int DIGITS   = 6,
  parameter int DW       = 6,
  parameter int BRIGHT_W = 3
) ();
  logic                   en;
  logic [DIGITS*DW-1:0]   din;
  logic [BRIGHT_W-1:0]    bright;
  logic [DW-1:0]          Dout;
  logic [DIGITS-1:0]      Eout;
  logic                   frame;

  modport master (output en, din, bright, input Dout, Eout, frame);
  modport slave  (input en, din, bright, output Dout, Eout, frame);
endinterface

// File: rtl/dyn_scan_n_prescaler.sv
// Step and PWM phase counters for one digit slot; slot_tick marks the
// last cycle of a slot.
module scan_prescaler
  import dyn_scan_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int BRIGHT_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [BRIGHT_W-1:0] phase,
  output logic                slot_tick
);

  localparam int unsigned STEP = calc_step(PRESCALE, BRIGHT_W);
  localparam int          SW   = cnt_w(STEP);
  localparam logic [SW-1:0]       STEP_LAST  = SW'(STEP - 1);
  localparam logic [BRIGHT_W-1:0] PHASE_LAST = '1;

  logic [SW-1:0]       step_q, step_d;
  logic [BRIGHT_W-1:0] phase_q, phase_d;
  logic                step_end;

  assign step_end = (step_q == STEP_LAST);

  always_comb begin
    step_d  = step_q;
    phase_d = phase_q;
    if (en) begin
      if (step_end) begin
        step_d  = '0;
        phase_d = phase_q + 1'b1;
      end else begin
        step_d  = step_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q  <= '0;
      phase_q <= '0;
    end else begin
      step_q  <= step_d;
      phase_q <= phase_d;
    end
  end

  assign phase     = phase_q;
  assign slot_tick = en & step_end & (phase_q == PHASE_LAST);

endmodule

// File: rtl/dyn_scan_n.sv
// N-digit multiplexed display scanner with PWM brightness and frame snapshot.
// Define DYN_SCAN_LZB_EN to enable leading-zero blanking.
module dyn_scan_n
  import dyn_scan_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int DW       = 6,
  parameter int PRESCALE = 1000,
  parameter int BRIGHT_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  dyn_scan_n_if.slave   bus
);

  if (!params_ok(DIGITS, PRESCALE, BRIGHT_W)) begin : g_param_check
    $error("dyn_scan_n: DIGITS must be >= 2 and PRESCALE a multiple of 2**BRIGHT_W");
  end

  localparam int IW = cnt_w(DIGITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [IW-1:0]         idx_q, idx_d;
  logic [DIGITS*DW-1:0]  shadow_q, shadow_d;
  logic                  primed_q, primed_d;
  logic [DW-1:0]         dout_q, dout_d;
  logic [DIGITS-1:0]     eout_q, eout_d;
  logic                  frame_q, frame_d;

  logic                  run, wrap, lit, slot_tick;
  logic [BRIGHT_W-1:0]   phase;
  logic [DIGITS-1:0]     blank_vec;

  // The priming cycle only captures din; counters start on the next cycle so
  // that slot 0 gets its full length from already-valid data.
  assign run = bus.en & primed_q;

  scan_prescaler #(
    .PRESCALE (PRESCALE),
    .BRIGHT_W (BRIGHT_W)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en        (run),
    .phase     (phase),
    .slot_tick (slot_tick)
  );

`ifdef DYN_SCAN_LZB_EN
  always_comb begin
    logic nz_above;
    nz_above  = 1'b0;
    blank_vec = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz_above     = nz_above | (|shadow_q[i*DW +: DW]);
      blank_vec[i] = ~nz_above;
    end
  end
`else
  assign blank_vec = '0;
`endif

  always_comb begin
    wrap     = slot_tick & (idx_q == IDX_LAST);
    idx_d    = idx_q;
    if (slot_tick) idx_d = wrap ? '0 : idx_q + 1'b1;
    primed_d = primed_q | bus.en;
    shadow_d = (wrap | (bus.en & ~primed_q)) ? bus.din : shadow_q;
    lit      = run & (phase <= bus.bright) & ~blank_vec[idx_q];
    eout_d   = lit ? DIGITS'(onehot(32'(idx_q), DIGITS)) : '0;
    dout_d   = lit ? shadow_q[idx_q*DW +: DW] : '0;
    frame_d  = wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q    <= '0;
      shadow_q <= '0;
      primed_q <= 1'b0;
      dout_q   <= '0;
      eout_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      primed_q <= primed_d;
      dout_q   <= dout_d;
      eout_q   <= eout_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.Dout  = dout_q;
  assign bus.Eout  = eout_q;
  assign bus.frame = frame_q;

endmodule

// File: doc/dyn_scan_n.md
# dyn_scan_n

Parametrised N-digit dynamic-display scanner with per-slot brightness (PWM) control, frame-synchronous input snapshot and optional leading-zero blanking. It is the generalised successor to the fixed six-digit scanner. The block sits between the digit-value logic (counters, clocks, BCD converters) and the segment decoder / digit-select pins. Digit count, data width, slot length and brightness resolution are all set by parameter.

## Interface
Parameters:
- DIGITS, 6: number of digits scanned; ≥2.
- DW, 6: bits per digit value; ≥1.
- PRESCALE, 1000: clk cycles per digit slot; must be a multiple of 2**BRIGHT_W.
- BRIGHT_W, 3: brightness control width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- en  in  1  scan enable.
- din  in  DIGITS*DW  digit values, digit i at din[i*DW +: DW]; digit 0 is least significant / rightmost.
- bright  in  BRIGHT_W  on-time level; 0 = dimmest, all-ones = full.
- Dout  out  DW  value of the currently selected digit.
- Eout  out  DIGITS  one-hot digit select, active-high.
- frame  out  1  one-cycle pulse at each frame start.

## Operation
- STEP = PRESCALE / 2**BRIGHT_W.
- Step counter counts 0..STEP-1.
- Phase counter advances on the step wrap and counts 0..2**BRIGHT_W-1.
- Digit index idx advances on the phase wrap and counts 0..DIGITS-1, then wraps to 0.
- Counter widths: $clog2 of each range, minimum 1.
- Shadow register holds DIGITS*DW bits. It loads din:
  - in the cycle idx wraps DIGITS-1→0, and
  - on the first en=1 cycle after reset (priming flag).
- Dout and Eout are always taken from the shadow register, never from live din.
- A digit is lit when en=1 and phase ≤ bright. Minimum duty is 1/2**BRIGHT_W; bright all-ones gives 100 %.
- Lit: Eout = one-hot(idx), Dout = shadow[idx]. Unlit: Eout = 0, Dout = 0.
- frame = 1 for one cycle on the idx wrap to 0 (the same cycle the shadow loads).
- en=0:
  - all counters hold their values;
  - Eout = 0, Dout = 0, frame = 0.
  - On re-enable, scanning resumes from the frozen idx/phase/step.
- bright change takes effect on the next cycle's compare; no resynchronisation.

## Timing
- Reset (rst=0), immediate and asynchronous: idx, phase, step, shadow, priming flag, Dout, Eout and frame all = 0.
- Dout, Eout and frame are registered. Each reflects the counter state from before the same edge, so output latency is 1 cycle.
- With en=1 from reset release, the first edge loads the shadow. Eout becomes 000001 one edge later.
- Slot length is exactly PRESCALE cycles. Frame length is DIGITS*PRESCALE cycles.
- din changes mid-frame are not visible until the next frame pulse (no tearing).
- Reset asserted mid-slot: outputs clear immediately. After release, scanning restarts at digit 0, phase 0.

## Configuration
- Macro: DYN_SCAN_LZB_EN.
- Defined: leading-zero blanking is enabled. Digit i > 0 is forced unlit (Eout = 0, Dout = 0) when the shadow values of digit i and every higher digit are all zero. Digit 0 is never blanked. Slot timing is unchanged; a blanked slot still lasts PRESCALE cycles.
- Undefined: every digit is lit according to brightness only.

## Structure
- Package dyn_scan_pkg holds:
  - a function onehot(idx, DIGITS);
  - a localparam helper for the STEP computation;
  - a parameter-legality check function used for elaboration-time asserts on the PRESCALE multiple and DIGITS≥2.
- Sub-module scan_prescaler:
  - contains the step and phase counters;
  - outputs phase and slot_tick;
  - honours en and rst.
- The top level holds idx, the shadow register, LZB logic and the output registers.

## Test plan
All scenarios use DIGITS=6, DW=6, PRESCALE=8, BRIGHT_W=2, so STEP=2.
- Basic scan: rst low 100 ns → high, en=1, bright=3, din digits 5..0 = 0,1,0,1,0,2.
  - Eout walks 000001→000010→…→100000, 8 cycles each.
  - Dout sequence is 2,0,1,0,1,0.
  - frame pulses every 48 cycles.
  - With DYN_SCAN_LZB_EN, slot 5 shows Eout=0 and digit 3 still lights.
- Brightness: bright=0 → each digit lit exactly 2 of 8 cycles (phase 0). bright=1 → lit 4 of 8.
- Enable gating: en=0 at cycle 3 of slot 2 → Eout=0 next cycle. en=1 10 cycles later → digit 2 finishes its remaining 5 cycles.
- Snapshot: change digit 0 from 2 to 7 mid-frame → Dout shows 2 until the next frame pulse, then 7.
- Reset mid-frame: rst=0 during slot 4 → Dout, Eout and frame = 0 with no clock edge. After release, Eout returns to 000001.
- All-zero LZB: din=0 with DYN_SCAN_LZB_EN → only digit 0 is lit (Dout=0). Slots 1–5 are dark for 8 cycles each.
